// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared definitions for the Wishbone command master
//
// Purpose: default bus widths, FSM state encoding and response status codes
//          shared by wb_cmd_master and its timeout timer.
// Ports:   none (package).
package wb_pkg;

  localparam int WB_DAT_WIDTH_DEF = 32;
  localparam int WB_ADR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Value driven on rsp_err_o
  localparam logic RSP_OK      = 1'b0;
  localparam logic RSP_TIMEOUT = 1'b1;

  // Saturation value of the timed-out transfer counter
  localparam logic [7:0] TO_CNT_SAT = 8'hFF;

endpackage

// File: rtl/wb_timeout_timer.sv
// rtl/wb_timeout_timer.sv - clear/enable counter with terminal-count flag
//
// Purpose: counts cycles a Wishbone strobe has been waiting for ack.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      force count to zero (has priority over enable)
//   enable     advance count by one (holds once terminal count is reached)
//   expired    high while count == TIMEOUT_CYCLES-1
module wb_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_CNT_WIDTH-1:0] TERMINAL = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_WIDTH-1:0] count;

  assign expired = (count == TERMINAL);

  // Holding at terminal count keeps the counter from wrapping if the
  // owner is a cycle late in clearing it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer initiator
//
// Purpose: takes read/write commands on a valid/ready port, runs one Wishbone
//          classic cycle per command and returns read data or a timeout error
//          on a valid/ready response port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake (ready only in IDLE)
//   cmd_we_i/cmd_adr_i/cmd_dat_i  command type, address, write data
//   rsp_valid_o/rsp_ready_i       response handshake
//   rsp_dat_o/rsp_err_o/rsp_we_o  read data, timeout flag, command type echo
//   wb_*                          Wishbone initiator signals
//   busy_o                        high while a command is in flight
//   timeout_cnt_o                 saturating count of timed-out transfers
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int WB_DAT_WIDTH   = WB_DAT_WIDTH_DEF,
  parameter int WB_ADR_WIDTH   = WB_ADR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [WB_ADR_WIDTH-1:0] cmd_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] cmd_dat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WB_DAT_WIDTH-1:0] rsp_dat_o,
  output logic                    rsp_err_o,
  output logic                    rsp_we_o,
  output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  output logic                    busy_o,
  output logic [7:0]              timeout_cnt_o
);

  wb_state_e state;
  logic      expired;

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);

  // Timer is held at zero outside BUS, so it restarts for every transfer.
  wb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_CNT_WIDTH  (TO_CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_BUS),
    .enable (state == ST_BUS),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= RSP_OK;
      rsp_we_o      <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // cmd_ready_o is implied by being in IDLE
          if (cmd_valid_i) begin
            wb_adr_o <= cmd_adr_i;
            wb_dat_o <= cmd_dat_i;
            wb_we_o  <= cmd_we_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          // ack is checked first so a last-cycle ack still completes normally
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_dat_o   <= wb_we_o ? '0 : wb_dat_i;
            rsp_err_o   <= RSP_OK;
            rsp_we_o    <= wb_we_o;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (expired) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= RSP_TIMEOUT;
            rsp_we_o    <= wb_we_o;
            rsp_valid_o <= 1'b1;
            if (timeout_cnt_o != TO_CNT_SAT) begin
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
            end
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - scoreboard bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam int T     = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        busy_o;
  logic [7:0]  timeout_cnt_o;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .WB_DAT_WIDTH  (32),
    .WB_ADR_WIDTH  (32),
    .TIMEOUT_CYCLES(T),
    .TO_CNT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_we_o     (rsp_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .wb_dat_i     (wb_dat_i),
    .busy_o       (busy_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        we;
    logic [7:0]  tocnt;
    int          lat;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem   [16];
  logic [31:0] slave_mem [16];
  logic [3:0]  buttons   = 4'b1010;
  int          to_model  = 0;
  logic        force_ack = 1'b0;
  bit          rdy_mode  = 1'b0;
  logic        rdy_val   = 1'b0;
  int          cyc_n     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference: ack lands on stb cycle d; anything past T is a timeout.
  task automatic accept_now(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input int d, input bit track);
    exp_t e;
    bus_t b;
    int   idx;
    b.d = d; b.adr = adr; b.dat = dat; b.we = we;
    bus_q.push_back(b);
    if (track) begin
      idx  = int'(adr[5:2]);
      e.we = we;
      if (d <= T) begin
        e.lat = d;
        e.err = 1'b0;
        if (we) begin
          if (idx != 0) ref_mem[idx] = dat;
          e.dat = '0;
        end else begin
          e.dat = (idx == 0) ? {28'b0, buttons} : ref_mem[idx];
        end
      end else begin
        e.lat = T;
        e.err = 1'b1;
        e.dat = '0;
        if (to_model < 255) to_model++;
      end
      e.tocnt = 8'(to_model);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input int d, input bit track);
    int t = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
    @(negedge clk);
    while (!cmd_ready_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready_o) begin
      chk1("accept_timeout", 1'b0, 1'b1);
      cmd_valid_i = 1'b0;
      @(posedge clk); #1;
    end else begin
      accept_now(we, adr, dat, d, track);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic int pick_d();
    case ($urandom % 10)
      0, 1, 2, 3, 4: return 1 + int'($urandom % 3);
      5:       return T;
      6:       return T - 1;
      7:       return T + 1;
      8:       return NEVER;
      default: return 4 + int'($urandom % 3);
    endcase
  endfunction

  always @(posedge clk) cyc_n = cyc_n + 1;

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready_i = rdy_mode ? rdy_val : (($urandom % 4) != 0);
    end
  end

  // Slave: acks on the d-th cycle of stb, memory-backed, word 0 = buttons.
  initial begin
    int   s_cnt = 0;
    int   s_d   = NEVER;
    int   idx;
    bus_t cur;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (wb_cyc_o && wb_stb_o) begin
        if (s_cnt == 0) begin
          chk1("bus_expected", bus_q.size() != 0, 1'b1);
          if (bus_q.size() != 0) begin
            cur = bus_q.pop_front();
            s_d = cur.d;
            chk("wb_adr", wb_adr_o, cur.adr);
            chk("wb_dat_o", wb_dat_o, cur.dat);
            chk1("wb_we", wb_we_o, cur.we);
          end else begin
            s_d = NEVER;
          end
        end
        s_cnt++;
        idx = int'(wb_adr_o[5:2]);
        if (s_cnt == s_d) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) begin
            if (idx != 0) slave_mem[idx] = wb_dat_o;
            wb_dat_i = $urandom;
          end else begin
            wb_dat_i = (idx == 0) ? {28'b0, buttons} : slave_mem[idx];
          end
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = $urandom;
        end
      end else begin
        s_cnt    = 0;
        wb_ack_i = force_ack;
        wb_dat_i = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: latency/strobe width at response rise, payload at handshake.
  initial begin
    int   accept_at = 0;
    int   stb_cnt   = 0;
    logic prev_v    = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stb_cnt = 0;
        prev_v  = 1'b0;
      end else begin
        if (cmd_valid_i && cmd_ready_o) accept_at = cyc_n + 1;
        if (wb_stb_o) stb_cnt++;
        if (rsp_valid_o && !prev_v) begin
          if (exp_q.size() == 0) begin
            chk1("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            chk("latency", cyc_n - accept_at, exp_q[0].lat);
            chk("stb_cycles", stb_cnt, exp_q[0].lat);
          end
          stb_cnt = 0;
        end
        if (rsp_valid_o && rsp_ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_dat", rsp_dat_o, e.dat);
          chk1("rsp_err", rsp_err_o, e.err);
          chk1("rsp_we", rsp_we_o, e.we);
          chk("timeout_cnt", {24'b0, timeout_cnt_o}, {24'b0, e.tocnt});
        end
        prev_v = rsp_valid_o;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_exp;
    int          t;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat_o", wb_dat_o, 32'h0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk1("rst_rsp_err", rsp_err_o, 1'b0);
    chk1("rst_rsp_we", rsp_we_o, 1'b0);
    chk("rst_tocnt", {24'b0, timeout_cnt_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // GPIO write then button read, one-wait-state slave
    issue(1'b1, 32'h0000_0004, 32'h0000_00A5, 2, 1'b1);
    drain();
    chk("gpio_out_reg", slave_mem[1], 32'h0000_00A5);
    issue(1'b0, 32'h0000_0000, $urandom, 2, 1'b1);
    drain();

    // Response back-pressure with a second command waiting
    rdy_mode = 1'b1;
    rdy_val  = 1'b0;
    hold_exp = ref_mem[15];
    issue(1'b0, 32'h0000_003C, $urandom, 2, 1'b1);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h14; cmd_dat_i = 32'h1234_5678;
    t = 0;
    @(negedge clk);
    while (!rsp_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", rsp_valid_o, 1'b1);
      chk("hold_dat", rsp_dat_o, hold_exp);
      chk1("hold_cmd_ready", cmd_ready_o, 1'b0);
      if (i < 4) @(negedge clk);
    end
    rdy_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("post_hs_cmd_ready", cmd_ready_o, 1'b1);
    chk1("post_hs_rsp_valid", rsp_valid_o, 1'b0);
    accept_now(1'b1, 32'h14, 32'h1234_5678, 3, 1'b1);
    drain();
    rdy_mode = 1'b0;

    // Ack on the last allowed cycle, then one cycle too late
    issue(1'b0, 32'h0000_0020, $urandom, T, 1'b1);
    issue(1'b0, 32'h0000_0024, $urandom, T + 1, 1'b1);
    drain();

    // Timeout counter saturation
    for (int i = 0; i < 256; i++) issue(1'b0, 32'h0000_0010, $urandom, NEVER, 1'b1);
    drain();
    chk("tocnt_saturated", {24'b0, timeout_cnt_o}, 32'd255);

    // Reset on the first BUS cycle, then a stray ack
    issue(1'b0, 32'h0000_0008, $urandom, NEVER, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    to_model = 0;
    @(negedge clk);
    chk1("mid_rst_cyc", wb_cyc_o, 1'b0);
    chk1("mid_rst_stb", wb_stb_o, 1'b0);
    chk1("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_tocnt", {24'b0, timeout_cnt_o}, 32'h0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("late_ack_busy", busy_o, 1'b0);
      chk1("late_ack_rsp_valid", rsp_valid_o, 1'b0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    issue(1'b0, 32'h0000_0008, $urandom, 2, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom % 2), $urandom, $urandom, pick_d(), 1'b1);
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-transfer initiator: the bus-master end of the interface our GPIO/peripheral slaves respond to. Accepts read/write commands on a valid/ready command port and runs one Wishbone cycle per command. Returns read data or a timeout error on a valid/ready response port. Sits between a local controller or test sequencer and the peripheral Wishbone bus; guards against absent or hung slaves.

Parameters:
WB_DAT_WIDTH, 32, Wishbone data width
WB_ADR_WIDTH, 32, Wishbone byte-address width
TIMEOUT_CYCLES, 255, max cycles stb may stay high without ack (≥2)
TO_CNT_WIDTH, 8, width of timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  WB_ADR_WIDTH  target address
cmd_dat_i  in  WB_DAT_WIDTH  write data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  WB_DAT_WIDTH  read data (0 for writes and errors)
rsp_err_o  out  1  1=timeout, no ack
rsp_we_o  out  1  echo of command type
wb_adr_o  out  WB_ADR_WIDTH  Wishbone address
wb_dat_o  out  WB_DAT_WIDTH  Wishbone write data
wb_we_o  out  1  Wishbone write enable
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_ack_i  in  1  Wishbone acknowledge
wb_dat_i  in  WB_DAT_WIDTH  Wishbone read data
busy_o  out  1  high in BUS or RESP
timeout_cnt_o  out  8  saturating count of timed-out transfers

Behaviour:
- Reset: state IDLE; cyc/stb/we=0, adr/dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, rsp_we=0, timeout_cnt=0, internal timer=0.
- All outputs registered, except cmd_ready_o = (state==IDLE) and busy_o = (state!=IDLE).
- IDLE: on cmd_valid&cmd_ready edge, latch adr/dat/we into wb_adr_o/wb_dat_o/wb_we_o, set cyc=stb=1, timer=0, go BUS.
- BUS: cyc=stb=1; adr/dat/we held stable.
  - Edge with wb_ack_i=1: cyc=stb=0; rsp_dat = wb_i for reads, 0 for writes; rsp_err=0; rsp_we=we; rsp_valid=1; go RESP.
  - Edge with no ack and timer==TIMEOUT_CYCLES-1: cyc=stb=0; rsp_dat=0; rsp_err=1; rsp_valid=1; timeout_cnt += 1, saturating at 255; go RESP.
  - Otherwise timer += 1.
  - stb is therefore high for at most TIMEOUT_CYCLES cycles.
- Ack and timeout on the same edge: ack wins, rsp_err=0.
- wb_ack_i outside BUS: ignored, no state change.
- RESP: rsp_valid held, rsp fields stable until rsp_valid&rsp_ready edge; then rsp_valid=0, go IDLE. No new command accepted in RESP.
- Latency with a 1-wait-state slave (registered ack gated by stb&cyc):
  - command accepted at edge N, stb high from N; ack sampled at N+2; rsp_valid high from N+2.
  - Back-to-back throughput with rsp_ready=1: one command per 4 cycles.
- wb_adr_o/wb_dat_o/wb_we_o keep their last values when idle.
- Reset mid-BUS or mid-RESP: at the reset edge cyc/stb drop, the pending response is discarded, all reset values apply; a late ack after reset is ignored.

Decomposition:
- Shared package wb_pkg holds:
  - WB_DAT_WIDTH/WB_ADR_WIDTH defaults
  - state encodings ST_IDLE=2'd0, ST_BUS=2'd1, ST_RESP=2'd2
  - RSP_OK/RSP_TIMEOUT constants
- One natural sub-module: wb_timeout_timer, a clear/enable/terminal-count counter parameterised by TIMEOUT_CYCLES. Its output `expired` is high when the count equals TIMEOUT_CYCLES-1.
- FSM and response register stay in the top level.

Test Plan:
- GPIO slave attached, write adr 0x0000_0004, data 0x0000_00A5 -> stb high 2 cycles; slave output register = 0xA5; rsp_valid with rsp_err=0, rsp_we=1, rsp_dat=0.
- GPIO slave, button inputs 4'b1010, read adr 0x0000_0000 -> rsp_dat=0x0000_000A, rsp_err=0, rsp_valid 2 cycles after accept.
- ack tied 0, TIMEOUT_CYCLES=8, read adr 0x10 -> cyc/stb high exactly 8 cycles; rsp_err=1, rsp_dat=0; timeout_cnt_o 0->1. Repeat 256 times -> timeout_cnt_o=255, saturated.
- rsp_ready held 0 for 5 cycles after a read of 0x3C -> rsp_valid/rsp_dat stable throughout; cmd_ready_o=0; a second cmd_valid is not accepted until the cycle after the handshake.
- rst asserted on cycle 1 of BUS -> cyc/stb=0 after that edge; no rsp_valid; late ack ignored; next command completes normally.
- Ack arriving on the same edge as timer expiry (TIMEOUT_CYCLES=4, ack on 4th stb cycle) -> rsp_err=0, read data captured, timeout_cnt unchanged.
